// File: rtl/numfmt_seq.sv
// Unsigned 16-bit to ASCII digit string converter (base 2..36) built on an
// external 16/8 divider. Digits are buffered, then streamed MSB first.
module numfmt_seq #(
  parameter int MAXDIG = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  input  logic [7:0]  base,
  input  logic [4:0]  minw,
  output logic        busy,
  output logic        err,
  output logic        ch_valid,
  input  logic        ch_ready,
  output logic [7:0]  ch_data,
  output logic        ch_last,
  output logic        div_go,
  output logic [15:0] div_dividend,
  output logic [7:0]  div_divisor,
  input  logic        div_busy,
  input  logic [7:0]  div_quot,
  input  logic [7:0]  div_rem,
  input  logic        div_overflow
);

  localparam int CW = $clog2(MAXDIG + 1);
  localparam int IW = $clog2(MAXDIG);

  typedef enum logic [2:0] {
    IDLE, CHK, HI_GO, HI_WAIT, LO_GO, LO_WAIT, STORE, EMIT
  } state_t;

  state_t state, state_nx;

  logic [15:0]   n;
  logic [7:0]    b;
  logic [CW-1:0] w;
  logic [CW-1:0] count;
  logic [7:0]    qh;
  logic [7:0]    rh;
  logic [7:0]    digit;
  logic          seen;
  logic [7:0]    dig_buf [MAXDIG];

  logic [CW-1:0] count_inc;
  logic [CW-1:0] count_dec;
  logic [CW-1:0] w_min1;
  logic          stop;
  logic          div_done;
  logic [7:0]    digit_ascii;

  assign count_inc   = count + CW'(1);
  assign count_dec   = count - CW'(1);
  assign w_min1      = (w == '0) ? CW'(1) : w;
  assign stop        = ((n == 16'h0000) && (count_inc >= w_min1)) || (count_inc == CW'(MAXDIG));
  assign div_done    = seen && !div_busy;
  assign digit_ascii = (digit < 8'd10) ? (8'h30 + digit) : (8'h37 + digit);

  // A divide completes on the first low div_busy cycle after it was seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n     <= '0;
      b     <= '0;
      w     <= '0;
      count <= '0;
      qh    <= '0;
      rh    <= '0;
      digit <= '0;
      seen  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            n     <= value;
            b     <= base;
            w     <= (int'(minw) > MAXDIG) ? CW'(MAXDIG) : CW'(minw);
            count <= '0;
          end
        end
        HI_GO, LO_GO: seen <= 1'b0;
        HI_WAIT: begin
          if (div_busy) seen <= 1'b1;
          else if (seen) begin
            qh <= div_quot;
            rh <= div_rem;
          end
        end
        LO_WAIT: begin
          if (div_busy) seen <= 1'b1;
          else if (seen) begin
            n     <= {qh, div_quot};
            digit <= div_rem;
          end
        end
        STORE: count <= count_inc;
        EMIT: if (ch_ready) count <= count_dec;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == STORE) dig_buf[count[IW-1:0]] <= digit_ascii;
  end

  always_comb begin
    state_nx     = state;
    busy         = (state != IDLE);
    err          = 1'b0;
    ch_valid     = 1'b0;
    ch_last      = 1'b0;
    ch_data      = 8'h00;
    div_go       = 1'b0;
    div_dividend = 16'h0000;
    div_divisor  = (state != IDLE) ? b : 8'h00;
    case (state)
      IDLE: if (start) state_nx = CHK;
      CHK: begin
        if ((b < 8'd2) || (b > 8'd36)) begin
          err      = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = HI_GO;
        end
      end
      HI_GO: begin
        div_go       = 1'b1;
        div_dividend = {8'h00, n[15:8]};
        state_nx     = HI_WAIT;
      end
      HI_WAIT: begin
        div_dividend = {8'h00, n[15:8]};
        if (div_done) begin
          if (div_overflow) begin
            err      = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = LO_GO;
          end
        end
      end
      LO_GO: begin
        div_go       = 1'b1;
        div_dividend = {rh, n[7:0]};
        state_nx     = LO_WAIT;
      end
      LO_WAIT: begin
        div_dividend = {rh, n[7:0]};
        if (div_done) begin
          if (div_overflow) begin
            err      = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = STORE;
          end
        end
      end
      STORE: state_nx = stop ? EMIT : HI_GO;
      EMIT: begin
        ch_valid = 1'b1;
        ch_data  = dig_buf[count_dec[IW-1:0]];
        ch_last  = (count == CW'(1));
        if (ch_ready && (count == CW'(1))) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_numfmt_seq.sv
// Self-checking bench for numfmt_seq with a behavioural 16/8 divider model,
// a vector table, a scoreboard queue of expected characters and a reset corner case.
module tb_numfmt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic [7:0]  base;
  logic [4:0]  minw;
  logic        busy;
  logic        err;
  logic        ch_valid;
  logic        ch_ready;
  logic [7:0]  ch_data;
  logic        ch_last;
  logic        div_go;
  logic [15:0] div_dividend;
  logic [7:0]  div_divisor;
  logic        div_busy;
  logic [7:0]  div_quot;
  logic [7:0]  div_rem;
  logic        div_overflow;

  int total = 0;
  int bad   = 0;

  logic [8:0] sb_q [$];

  typedef struct {
    logic [15:0]  value;
    logic [7:0]   base;
    logic [4:0]   minw;
    int           exp_err;
    int           exp_len;
    logic [127:0] exp_chars;
    logic         stall;
  } vec_t;

  vec_t vecs [10];

  numfmt_seq #(.MAXDIG(16)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .base(base), .minw(minw),
    .busy(busy), .err(err), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_data(ch_data), .ch_last(ch_last), .div_go(div_go),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_busy(div_busy),
    .div_quot(div_quot), .div_rem(div_rem), .div_overflow(div_overflow)
  );

  always #5 clk = ~clk;

  // Divider stand-in: busy the cycle after go, results valid when busy drops.
  logic [15:0] dv_n;
  logic [7:0]  dv_d;
  int          dv_cnt;
  always @(posedge clk) begin
    if (rst) begin
      div_busy     <= 1'b0;
      div_quot     <= 8'h00;
      div_rem      <= 8'h00;
      div_overflow <= 1'b0;
      dv_cnt       <= 0;
    end else if (div_busy) begin
      if (dv_cnt == 0) begin
        div_busy <= 1'b0;
        if ((dv_d == 8'h00) || ((dv_n / {8'h00, dv_d}) > 16'd255)) begin
          div_overflow <= 1'b1;
          div_quot     <= 8'hFF;
          div_rem      <= 8'hFF;
        end else begin
          div_overflow <= 1'b0;
          div_quot     <= 8'(dv_n / {8'h00, dv_d});
          div_rem      <= 8'(dv_n % {8'h00, dv_d});
        end
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end else if (div_go) begin
      div_busy <= 1'b1;
      dv_n     <= div_dividend;
      dv_d     <= div_divisor;
      dv_cnt   <= 2;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic void modelFmt(input logic [15:0] v, input logic [7:0] bs, input logic [4:0] mw,
                                   output int len, output logic [127:0] chars);
    int nv, d, wl;
    nv = int'(v);
    wl = (int'(mw) > 16) ? 16 : int'(mw);
    if (wl == 0) wl = 1;
    len = 0;
    chars = '0;
    while (((nv != 0) || (len < wl)) && (len < 16)) begin
      d = nv % int'(bs);
      nv = nv / int'(bs);
      chars[len*8 +: 8] = (d < 10) ? 8'(8'h30 + d) : 8'(8'h37 + d);
      len++;
    end
  endfunction

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < v.exp_len; i++)
      sb_q.push_back({(i == v.exp_len - 1), v.exp_chars[(v.exp_len-1-i)*8 +: 8]});
    @(negedge clk);
    value = v.value;
    base  = v.base;
    minw  = v.minw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_on", 64'(busy), 64'd1);
  endtask

  task automatic runConversion(input vec_t v, input string tag);
    int errs, valids, cyc;
    logic done, held;
    logic [8:0] held_val, expv;
    errs = 0; valids = 0; cyc = 0; done = 1'b0; held = 1'b0; held_val = '0;
    applyStimulus(v);
    for (int c = 0; c < 1000 && !done; c++) begin
      if (c > 0) @(negedge clk);
      ch_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) checkOutput({tag, "_stable"}, 64'({ch_valid, ch_last, ch_data}), 64'({1'b1, held_val}));
      if (err) errs++;
      held = 1'b0;
      if (ch_valid) begin
        valids++;
        if (ch_ready) begin
          if (sb_q.size() == 0) begin
            checkOutput({tag, "_extra_char"}, 64'({ch_last, ch_data}), 64'h1FF);
          end else begin
            expv = sb_q.pop_front();
            checkOutput({tag, "_char"}, 64'({ch_last, ch_data}), 64'(expv));
          end
        end else begin
          held     = 1'b1;
          held_val = {ch_last, ch_data};
        end
      end
      if (!busy) begin
        done = 1'b1;
        cyc  = c;
      end
    end
    ch_ready = 1'b1;
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_err"}, 64'(errs), 64'(v.exp_err));
    checkOutput({tag, "_left"}, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    if (v.exp_err != 0) begin
      checkOutput({tag, "_no_valid"}, 64'(valids), 64'd0);
      checkOutput({tag, "_quick_idle"}, 64'(cyc <= 3), 64'd1);
    end
  endtask

  function automatic logic [63:0] outVector();
    return 64'({busy, err, ch_valid, ch_last, div_go, ch_data, div_dividend, div_divisor});
  endfunction

  initial begin
    vec_t rv;
    logic saw;
    rst = 1'b1; start = 1'b0; value = '0; base = '0; minw = '0; ch_ready = 1'b1;

    vecs[0] = '{16'd46845, 8'd10, 5'd0,  0, 5,  128'("46845"), 1'b0};
    vecs[1] = '{16'd0,     8'd10, 5'd0,  0, 1,  128'("0"), 1'b0};
    vecs[2] = '{16'd0,     8'd10, 5'd3,  0, 3,  128'("000"), 1'b0};
    vecs[3] = '{16'd255,   8'd16, 5'd4,  0, 4,  128'("00FF"), 1'b0};
    vecs[4] = '{16'd65535, 8'd2,  5'd0,  0, 16, 128'("1111111111111111"), 1'b0};
    vecs[5] = '{16'd35,    8'd36, 5'd0,  0, 1,  128'("Z"), 1'b0};
    vecs[6] = '{16'd1,     8'd1,  5'd0,  1, 0,  128'(0), 1'b0};
    vecs[7] = '{16'd5,     8'd37, 5'd0,  1, 0,  128'(0), 1'b0};
    vecs[8] = '{16'd46845, 8'd10, 5'd0,  0, 5,  128'("46845"), 1'b1};
    vecs[9] = '{16'd7,     8'd10, 5'd20, 0, 16, 128'("0000000000000007"), 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", outVector(), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) runConversion(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rv.value = 16'($urandom);
      rv.base  = 8'($urandom_range(2, 36));
      rv.minw  = 5'($urandom_range(0, 20));
      rv.exp_err = 0;
      rv.stall = 1'($urandom_range(0, 1));
      modelFmt(rv.value, rv.base, rv.minw, rv.exp_len, rv.exp_chars);
      runConversion(rv, $sformatf("rnd%0d", i));
    end

    // Reset while the high-half divide is in flight.
    @(negedge clk);
    value = 16'd46845; base = 8'd10; minw = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 20 && !saw; c++) begin
      if (div_busy) saw = 1'b1;
      else @(negedge clk);
    end
    checkOutput("rst_div_busy_seen", 64'(saw), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_outputs", outVector(), 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("rst_quiet", 64'({busy, div_go, ch_valid, err}), 64'd0);
    end
    rv = '{16'd1234, 8'd10, 5'd0, 0, 4, 128'("1234"), 1'b0};
    runConversion(rv, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
